// File: rtl/knn_vote_merge.sv
// K-nearest-neighbour vote merge: keeps the K closest (distance, label) candidates of a query,
// tallies their labels and emits the majority label over an ap_vld/ap_ack stream.
module knn_vote_merge #(
    parameter int K          = 3,
    parameter int NUM_CAND   = 8,
    parameter int DIST_BITS  = 28,
    parameter int LABEL_BITS = 4,
    parameter int NUM_LABELS = 10
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        ap_start,
    output logic        ap_idle,
    output logic        ap_done,
    output logic        ap_ready,
    input  logic [31:0] Input_1_V_V,
    input  logic        Input_1_V_V_ap_vld,
    output logic        Input_1_V_V_ap_ack,
    output logic [31:0] Output_1_V_V,
    output logic        Output_1_V_V_ap_vld,
    input  logic        Output_1_V_V_ap_ack
);
    localparam int CW   = $clog2(K + 1);
    localparam int CNTW = $clog2(NUM_CAND + 1);
    localparam int IW   = $clog2(K + NUM_LABELS + 1);

    typedef enum logic [1:0] {COLLECT, TALLY, PICK, SEND} state_t;

    state_t                state;
    logic [DIST_BITS-1:0]  slot_dist  [K];
    logic [LABEL_BITS-1:0] slot_label [K];
    logic [CW-1:0]         votes      [NUM_LABELS];
    logic [CNTW-1:0]       count;
    logic [IW-1:0]         idx;
    logic [LABEL_BITS-1:0] best;
    logic [CW-1:0]         best_cnt;
    logic                  out_vld;
    logic [31:0]           out_data;

    logic [DIST_BITS-1:0]  cand_dist;
    logic [LABEL_BITS-1:0] cand_label;
    logic [K-1:0]          ahead;
    logic [DIST_BITS-1:0]  ins_dist  [K];
    logic [LABEL_BITS-1:0] ins_label [K];
    logic [LABEL_BITS-1:0] tally_label;
    logic [CW-1:0]         pick_cnt;
    logic                  take;

    assign cand_dist  = Input_1_V_V[31:LABEL_BITS];
    assign cand_label = Input_1_V_V[LABEL_BITS-1:0];

    // ahead is a thermometer code: every slot whose distance is <= the candidate stays in place,
    // so equal distances keep arrival order and a candidate behind all K slots is dropped.
    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_ins
            assign ahead[gi] = (slot_dist[gi] <= cand_dist);
            if (gi == 0) begin : g_first
                assign ins_dist[gi]  = ahead[gi] ? slot_dist[gi]  : cand_dist;
                assign ins_label[gi] = ahead[gi] ? slot_label[gi] : cand_label;
            end else begin : g_rest
                assign ins_dist[gi]  = ahead[gi] ? slot_dist[gi]
                                     : (ahead[gi-1] ? cand_dist : slot_dist[gi-1]);
                assign ins_label[gi] = ahead[gi] ? slot_label[gi]
                                     : (ahead[gi-1] ? cand_label : slot_label[gi-1]);
            end
        end
    endgenerate

    always_comb begin
        tally_label = '0;
        for (int i = 0; i < K; i++)
            if (idx == IW'(i)) tally_label = slot_label[i];
        pick_cnt = '0;
        for (int i = 0; i < NUM_LABELS; i++)
            if (idx == IW'(i)) pick_cnt = votes[i];
    end

    assign Input_1_V_V_ap_ack  = ap_rst_n && ap_start && (state == COLLECT);
    assign take                = Input_1_V_V_ap_ack && Input_1_V_V_ap_vld;
    assign Output_1_V_V        = out_data;
    assign Output_1_V_V_ap_vld = out_vld;
    assign ap_done             = out_vld && Output_1_V_V_ap_ack;
    assign ap_ready            = ap_done;
    assign ap_idle             = (state == COLLECT) && (count == '0);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state    <= COLLECT;
            count    <= '0;
            idx      <= '0;
            best     <= '0;
            best_cnt <= '0;
            out_vld  <= 1'b0;
            out_data <= '0;
            for (int i = 0; i < K; i++) begin
                slot_dist[i]  <= '1;
                slot_label[i] <= '0;
            end
            for (int i = 0; i < NUM_LABELS; i++) votes[i] <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (take) begin
                        for (int i = 0; i < K; i++) begin
                            slot_dist[i]  <= ins_dist[i];
                            slot_label[i] <= ins_label[i];
                        end
                        if (count == CNTW'(NUM_CAND - 1)) begin
                            count <= '0;
                            idx   <= '0;
                            state <= TALLY;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                TALLY: begin
                    // Out-of-range labels match no counter and are silently skipped.
                    for (int i = 0; i < NUM_LABELS; i++)
                        if (tally_label == LABEL_BITS'(i)) votes[i] <= votes[i] + 1'b1;
                    if (idx == IW'(K - 1)) begin
                        idx      <= '0;
                        best     <= '0;
                        best_cnt <= '0;
                        state    <= PICK;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                PICK: begin
                    // Strictly-greater replacement makes ties resolve to the lower label.
                    if (pick_cnt > best_cnt) begin
                        best     <= LABEL_BITS'(idx);
                        best_cnt <= pick_cnt;
                    end
                    if (idx == IW'(NUM_LABELS - 1)) begin
                        idx   <= '0;
                        state <= SEND;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                SEND: begin
                    if (!out_vld) begin
                        out_vld  <= 1'b1;
                        out_data <= 32'(best);
                    end else if (Output_1_V_V_ap_ack) begin
                        out_vld  <= 1'b0;
                        best     <= '0;
                        best_cnt <= '0;
                        state    <= COLLECT;
                        for (int i = 0; i < K; i++) begin
                            slot_dist[i]  <= '1;
                            slot_label[i] <= '0;
                        end
                        for (int i = 0; i < NUM_LABELS; i++) votes[i] <= '0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule
